// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller and its compare unit.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} march_op_t;

  typedef struct packed {
    logic      down;     // 1 = addresses run CAPACITY..0
    logic      two_ops;  // element performs op0 then op1 at each address
    march_op_t op0;
    march_op_t op1;
  } march_elem_t;

  localparam int MARCH_ELEMS  = 6;
  localparam int READ_LATENCY = 2;

  // March C-: up(w0); up(r0,w1); up(r1,w0); dn(r0,w1); dn(r1,w0); up(r0)
  localparam march_elem_t MARCH_TABLE [MARCH_ELEMS] = '{
    '{1'b0, 1'b0, OP_W0, OP_W0},
    '{1'b0, 1'b1, OP_R0, OP_W1},
    '{1'b0, 1'b1, OP_R1, OP_W0},
    '{1'b1, 1'b1, OP_R0, OP_W1},
    '{1'b1, 1'b1, OP_R1, OP_W0},
    '{1'b0, 1'b0, OP_R0, OP_R0}
  };

  function automatic logic op_is_write(input march_op_t op);
    return (op == OP_W0) || (op == OP_W1);
  endfunction

  // "1" ops use the inverted background
  function automatic logic op_inverted(input march_op_t op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data checker: carries {valid, addr, expected} alongside each read for the read latency,
// then compares against mem_rdata and logs first failing address and a saturating fail count.
module mbist_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam int LAST = READ_LATENCY - 1;

  logic                  valid_reg [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_reg  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] exp_reg   [READ_LATENCY];
  logic                  mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        addr_reg[i]  <= '0;
        exp_reg[i]   <= '0;
      end
    end else begin
      valid_reg[0] <= rd_valid && !clear;
      addr_reg[0]  <= rd_addr;
      exp_reg[0]   <= rd_exp;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1] && !clear;
        addr_reg[i]  <= addr_reg[i-1];
        exp_reg[i]   <= exp_reg[i-1];
      end
    end
  end

  // Case-inequality so undriven/unknown read data is reported as a failure
  assign mismatch = valid_reg[LAST] && (mem_rdata !== exp_reg[LAST]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (clear) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) fail_addr <= addr_reg[LAST];
      if (fail_count != {CNT_WIDTH{1'b1}}) fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine for a single-port test memory: GEN -> ISSUE pipeline plus read checker.
// Define MBIST_CHECKERBOARD_EN to append a second pass with a 0x55../0xAA.. background.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef MBIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  // After the last GEN cycle: one GEN->ISSUE stage, the issue itself, then the read latency
  localparam int DRAIN_CYCLES = READ_LATENCY + 2;

  state_t                state_reg;
  logic [2:0]            elem_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  op_idx_reg;
  logic                  pass_reg;
  logic [2:0]            drain_cnt_reg;

  logic                  gen_valid_reg;
  logic                  gen_write_reg;
  logic [ADDR_WIDTH-1:0] gen_addr_reg;
  logic [DATA_WIDTH-1:0] gen_data_reg;
  logic                  issue_rd_valid_reg;
  logic [DATA_WIDTH-1:0] issue_exp_reg;

  march_elem_t           cur_elem;
  march_elem_t           next_elem;
  logic [2:0]            next_elem_idx;
  march_op_t             gen_op;
  logic [DATA_WIDTH-1:0] background;
  logic [DATA_WIDTH-1:0] gen_data;
  logic                  last_op_in_addr;
  logic                  last_addr;
  logic                  last_elem;
  logic                  last_pass;
  logic                  accept;

`ifdef MBIST_CHECKERBOARD_EN
  logic [DATA_WIDTH-1:0] checker_bg;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_checker
    assign checker_bg[gi] = ((gi % 2) == 0);
  end

  assign background = pass_reg ? checker_bg : '0;
`else
  assign background = '0;
`endif

  assign last_elem       = (elem_reg == 3'(MARCH_ELEMS - 1));
  assign next_elem_idx   = last_elem ? 3'd0 : elem_reg + 3'd1;
  assign cur_elem        = MARCH_TABLE[elem_reg];
  assign next_elem       = MARCH_TABLE[next_elem_idx];
  assign gen_op          = op_idx_reg ? cur_elem.op1 : cur_elem.op0;
  assign gen_data        = op_inverted(gen_op) ? ~background : background;
  assign last_op_in_addr = !cur_elem.two_ops || op_idx_reg;
  assign last_addr       = cur_elem.down ? (addr_reg == '0)
                                         : (addr_reg == ADDR_WIDTH'(CAPACITY));
  assign last_pass       = (pass_reg == 1'(PASSES - 1));
  assign accept          = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      elem_reg      <= '0;
      addr_reg      <= '0;
      op_idx_reg    <= 1'b0;
      pass_reg      <= 1'b0;
      drain_cnt_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= RUN;
            elem_reg   <= '0;
            addr_reg   <= '0;
            op_idx_reg <= 1'b0;
            pass_reg   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          if (!last_op_in_addr) begin
            op_idx_reg <= 1'b1;
          end else begin
            op_idx_reg <= 1'b0;
            if (!last_addr) begin
              addr_reg <= cur_elem.down ? addr_reg - 1'b1 : addr_reg + 1'b1;
            end else if (!last_elem) begin
              elem_reg <= next_elem_idx;
              addr_reg <= next_elem.down ? ADDR_WIDTH'(CAPACITY) : '0;
            end else if (!last_pass) begin
              elem_reg <= '0;
              addr_reg <= '0;
              pass_reg <= 1'b1;
            end else begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == 3'(DRAIN_CYCLES - 1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // GEN registers wdata early; ISSUE puts op/address on the bus one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_valid_reg      <= 1'b0;
      gen_write_reg      <= 1'b0;
      gen_addr_reg       <= '0;
      gen_data_reg       <= '0;
      mem_wdata          <= '0;
      mem_write_read     <= 1'b0;
      mem_address        <= '0;
      issue_rd_valid_reg <= 1'b0;
      issue_exp_reg      <= '0;
    end else begin
      gen_valid_reg <= (state_reg == RUN);
      if (state_reg == RUN) begin
        gen_write_reg <= op_is_write(gen_op);
        gen_addr_reg  <= addr_reg;
        gen_data_reg  <= gen_data;
        if (op_is_write(gen_op)) mem_wdata <= gen_data;
      end
      mem_write_read     <= gen_valid_reg && gen_write_reg;
      issue_rd_valid_reg <= gen_valid_reg && !gen_write_reg;
      if (gen_valid_reg) begin
        mem_address   <= gen_addr_reg;
        issue_exp_reg <= gen_data_reg;
      end
    end
  end

  mbist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .rd_valid   (issue_rd_valid_reg),
    .rd_addr    (mem_address),
    .rd_exp     (issue_exp_reg),
    .mem_rdata  (mem_rdata),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_count (fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Randomized self-checking bench for mbist_march_ctrl against a March C- reference model.
// Honours MBIST_CHECKERBOARD_EN to expect the second checkerboard pass.
module tb_mbist_march_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 15;
  localparam int CW  = 8;
  localparam int N   = CAP + 1;
`ifdef MBIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int NOPS = 10 * N * PASSES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, mem_write_read;
  logic [AW-1:0] fail_addr, mem_address;
  logic [CW-1:0] fail_count;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CAPACITY   (CAP),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .fail_addr      (fail_addr),
    .fail_count     (fail_count),
    .mem_write_read (mem_write_read),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Test memory: fault 0 = ideal, 1 = address never written (reads a junk value
  // standing in for X), 2 = one bit stuck at 1.
  int            fault_kind = 0;
  int            fault_addr = 0;
  int            fault_bit  = 0;
  logic          load_en = 1'b0;
  logic [DW-1:0] load_mem [N];
  logic [DW-1:0] tb_mem [N];
  logic [DW-1:0] wdata_q, rd_q1, rd_q2;

  function automatic logic [DW-1:0] read_word(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = tb_mem[a];
    if (fault_kind == 2 && int'(a) == fault_addr) v[fault_bit] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (load_en) tb_mem <= load_mem;
    else if (mem_write_read && !(fault_kind == 1 && int'(mem_address) == fault_addr))
      tb_mem[mem_address] <= wdata_q;
    wdata_q <= mem_wdata;
    rd_q1   <= read_word(mem_address);
    rd_q2   <= rd_q1;
  end
  assign mem_rdata = rd_q2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] out_vec();
    return {busy, done, fail, fail_addr, fail_count, mem_write_read, mem_address, mem_wdata};
  endfunction

  // Reference model: March C- as a list of element strings
  string     el_ops  [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  int        el_down [6] = '{0, 0, 0, 1, 1, 0};
  logic [12:0] exp_q [$];
  int        exp_cnt, exp_addr, exp_writes;

  task automatic build_model(input int fk, input int fa, input int fb);
    logic [DW-1:0] rmem [N];
    logic [DW-1:0] bg, val, got;
    string         ops;
    int            a;
    exp_q.delete();
    exp_cnt = 0; exp_addr = 0; exp_writes = 0;
    for (int i = 0; i < N; i++) rmem[i] = load_mem[i];
    for (int p = 0; p < PASSES; p++) begin
      bg = (p == 0) ? 8'h00 : 8'h55;
      for (int e = 0; e < 6; e++) begin
        ops = el_ops[e];
        for (int j = 0; j < N; j++) begin
          a = (el_down[e] != 0) ? N - 1 - j : j;
          for (int k = 0; k < ops.len(); k += 2) begin
            val = (ops.getc(k + 1) == "1") ? ~bg : bg;
            if (ops.getc(k) == "w") begin
              exp_q.push_back({1'b1, AW'(a), val});
              exp_writes++;
              if (!(fk == 1 && a == fa)) rmem[a] = val;
            end else begin
              exp_q.push_back({1'b0, AW'(a), 8'h00});
              got = rmem[a];
              if (fk == 2 && a == fa) got[fb] = 1'b1;
              if (got != val) begin
                if (exp_cnt == 0) exp_addr = a;
                exp_cnt++;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic prepare(input int fk, input int fa, input int fb);
    @(negedge clk);
    fault_kind = fk; fault_addr = fa; fault_bit = fb;
    for (int i = 0; i < N; i++) load_mem[i] = DW'($urandom);
    if (fk == 1) load_mem[fa] = 8'hA5;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    build_model(fk, fa, fb);
  endtask

  task automatic run_test(input string tag, input int fk, input int fa, input int fb, input int restart_at);
    int            bus_cyc, done_cyc, writes, reads, stray, busy_drop;
    logic [DW-1:0] prev_wdata;
    logic [12:0]   obs;
    prepare(fk, fa, fb);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    start = 1'b1;
    bus_cyc = -1; done_cyc = -1; writes = 0; reads = 0; stray = 0; busy_drop = 0;
    prev_wdata = mem_wdata;
    for (int i = 0; i < NOPS + 60 && done_cyc < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) check({tag, " busy_on_accept"}, 32'(busy), 32'd1);
      if (bus_cyc < 0 && mem_write_read) bus_cyc = 0;
      else if (bus_cyc >= 0) bus_cyc++;
      if (bus_cyc >= 0 && bus_cyc < NOPS) begin
        obs = {mem_write_read, mem_address, mem_write_read ? prev_wdata : 8'h00};
        check($sformatf("%s op%0d", tag, bus_cyc), 32'(obs), 32'(exp_q[bus_cyc]));
        if (mem_write_read) writes++; else reads++;
      end else if (bus_cyc >= NOPS && mem_write_read) begin
        stray++;
      end
      if (done) done_cyc = bus_cyc;
      else if (!busy) busy_drop++;
      if (bus_cyc == restart_at) start = 1'b1;
      prev_wdata = mem_wdata;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(NOPS + 2));
    check({tag, " writes"}, 32'(writes), 32'(exp_writes));
    check({tag, " reads"}, 32'(reads), 32'(NOPS - exp_writes));
    check({tag, " stray_writes"}, 32'(stray), 32'd0);
    check({tag, " busy_gap"}, 32'(busy_drop), 32'd0);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " fail"}, 32'(fail), 32'(exp_cnt != 0));
    check({tag, " fail_addr"}, 32'(fail_addr), 32'(exp_addr));
    check({tag, " fail_count"}, 32'(fail_count), 32'(exp_cnt));
    $display("run %s: fault=%0d addr=%0d bit=%0d done_cyc=%0d fail=%0d fail_addr=%0d fail_count=%0d",
             tag, fk, fa, fb, done_cyc, fail, fail_addr, fail_count);
  endtask

  task automatic reset_test();
    int bus_cyc, writes, flags;
    prepare(0, 0, 0);
    start = 1'b1;
    bus_cyc = -1;
    for (int i = 0; i < 100 && bus_cyc < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus_cyc < 0 && mem_write_read) bus_cyc = 0;
      else if (bus_cyc >= 0) bus_cyc++;
    end
    check("rst reach_cycle40", 32'(bus_cyc), 32'd40);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst outputs_in_reset", 32'(out_vec()), 32'd0);
    end
    rst_n = 1'b1;
    writes = 0; flags = 0;
    repeat (30) begin
      @(negedge clk);
      if (mem_write_read) writes++;
      if (busy || done || fail) flags++;
    end
    check("rst no_writes_after", 32'(writes), 32'd0);
    check("rst idle_after", 32'(flags), 32'd0);
    $display("run reset_mid_run: reached=%0d writes_after=%0d", bus_cyc, writes);
  endtask

  initial begin
    int fk, fa, fb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'(out_vec()), 32'd0);
    rst_n = 1'b1;

    run_test("ideal", 0, 0, 0, -1);
    run_test("wrong_addr5", 1, 5, 0, -1);
    run_test("stuck1_addr9", 2, 9, 0, -1);
    reset_test();
    run_test("after_reset", 0, 0, 0, -1);
    run_test("restart_c50", 0, 0, 0, 50);
    for (int r = 0; r < 4; r++) begin
      fk = $urandom_range(0, 2);
      fa = $urandom_range(0, N - 1);
      fb = $urandom_range(0, DW - 1);
      run_test($sformatf("random%0d", r), fk, fa, fb, $urandom_range(0, NOPS - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
